// File: rtl/sym_fir_pkg.sv
// sym_fir_pkg: shared types, width derivations and the round/saturate helper for sym_fir_core.
package sym_fir_pkg;

    typedef enum logic {MODE_SYM = 1'b0, MODE_ASYM = 1'b1} sym_mode_e;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_SWAP} fir_state_e;

    function automatic int pre_w(input int dw);
        return dw + 1;
    endfunction

    function automatic int prod_w(input int dw, input int cw);
        return pre_w(dw) + cw;
    endfunction

    function automatic int acc_w(input int dw, input int cw, input int n);
        return prod_w(dw, cw) + $clog2(n);
    endfunction

    // Returns {saturated, value}; value is round-half-up by sh bits, clipped to ow signed bits.
    function automatic logic [64:0] round_sat(input logic signed [63:0] v, input int sh, input int ow);
        logic signed [63:0] r, mx, mn;
        r  = sh > 0 ? (v + (64'sd1 <<< (sh - 1))) >>> sh : v;
        mx = (64'sd1 <<< (ow - 1)) - 64'sd1;
        mn = -(64'sd1 <<< (ow - 1));
        return r > mx ? {1'b1, mx} : r < mn ? {1'b1, mn} : {1'b0, r};
    endfunction

endpackage

// File: rtl/sym_fir_round_sat.sv
// sym_fir_round_sat: combinational round-half-up and saturation of the accumulator into the output word.
module sym_fir_round_sat
    import sym_fir_pkg::*;
#(
    parameter int IN_W  = 27,
    parameter int SHIFT = 1,
    parameter int OUT_W = 20
) (
    input  logic signed [IN_W-1:0]  din_i,
    output logic signed [OUT_W-1:0] dout_o,
    output logic                    sat_o
);

    logic [64:0] rs;
    logic        unused_hi;

    assign rs        = round_sat(64'(din_i), SHIFT, OUT_W);
    assign dout_o    = rs[OUT_W-1:0];
    assign sat_o     = rs[64];
    assign unused_hi = ^rs[63:OUT_W];

endmodule

// File: rtl/sym_fir_core.sv
// sym_fir_core: pipelined linear-phase FIR with shadow coefficient bank and drain-then-swap commit.
// Define ADAPTIVE_FILTER_SAT_CNT_EN to add the saturating sat_cnt output counter.
module sym_fir_core
    import sym_fir_pkg::*;
#(
    parameter int ORDER      = 9,
    parameter int DATA_WIDTH = 14,
    parameter int DATA_FL    = 6,
    parameter int COEF_WIDTH = 9,
    parameter int COEF_FL    = 7,
    parameter int OUT_WIDTH  = 20,
    parameter int OUT_FL     = 12
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_WIDTH-1:0]              in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [OUT_WIDTH-1:0]               out_data,
    output logic                               out_sat,
    input  logic                               coef_wr_en,
    input  logic [$clog2((ORDER + 1) / 2)-1:0] coef_wr_addr,
    input  logic [COEF_WIDTH-1:0]              coef_wr_data,
    input  logic                               coef_commit,
    input  logic                               mode,
    output logic                               commit_busy
`ifdef ADAPTIVE_FILTER_SAT_CNT_EN
    ,output logic [15:0]                       sat_cnt
`endif
);

    localparam int COEF_NUM = (ORDER + 1) / 2;
    localparam int PRE_W    = pre_w(DATA_WIDTH);
    localparam int PROD_W   = prod_w(DATA_WIDTH, COEF_WIDTH);
    localparam int ACC_W    = acc_w(DATA_WIDTH, COEF_WIDTH, COEF_NUM);
    localparam int SHIFT    = DATA_FL + COEF_FL - OUT_FL;

    if ((ORDER % 2) == 0 || OUT_FL > DATA_FL + COEF_FL) begin : g_param_check
        $error("sym_fir_core: ORDER must be odd and OUT_FL <= DATA_FL + COEF_FL");
    end

    fir_state_e                   state_q;
    sym_mode_e                    mode_q;
    logic                         commit_busy_q, out_valid_q, out_sat_q, rs_sat, stall, accept;
    logic [3:0]                   vld_q;
    logic signed [DATA_WIDTH-1:0] x_q      [ORDER+1];
    logic signed [COEF_WIDTH-1:0] shadow_q [COEF_NUM];
    logic signed [COEF_WIDTH-1:0] active_q [COEF_NUM];
    logic signed [PRE_W-1:0]      p_q      [COEF_NUM];
    logic signed [PROD_W-1:0]     m_q      [COEF_NUM];
    logic signed [ACC_W-1:0]      sum_q, sum_d;
    logic signed [OUT_WIDTH-1:0]  out_data_q, rs_data;

    assign stall       = out_valid_q && !out_ready;
    assign in_ready    = !stall && state_q == ST_RUN;
    assign accept      = in_valid && in_ready;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_sat     = out_sat_q;
    assign commit_busy = commit_busy_q;

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < COEF_NUM; k++) sum_d = sum_d + ACC_W'(m_q[k]);
    end

    sym_fir_round_sat #(.IN_W(ACC_W), .SHIFT(SHIFT), .OUT_W(OUT_WIDTH)) u_round_sat (
        .din_i  (sum_q),
        .dout_o (rs_data),
        .sat_o  (rs_sat)
    );

    // vld_q[0] marks a fresh sample in the delay line; vld_q[3] marks a valid accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= ORDER; k++) x_q[k] <= '0;
            for (int k = 0; k < COEF_NUM; k++) begin
                p_q[k] <= '0;
                m_q[k] <= '0;
            end
            sum_q       <= '0;
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else if (!stall) begin
            if (accept) begin
                x_q[0] <= in_data;
                for (int k = 1; k <= ORDER; k++) x_q[k] <= x_q[k-1];
            end
            for (int k = 0; k < COEF_NUM; k++) begin
                p_q[k] <= mode_q == MODE_ASYM ? PRE_W'(x_q[k]) - PRE_W'(x_q[ORDER-k])
                                              : PRE_W'(x_q[k]) + PRE_W'(x_q[ORDER-k]);
                m_q[k] <= PROD_W'(p_q[k]) * PROD_W'(active_q[k]);
            end
            sum_q       <= sum_d;
            vld_q       <= {vld_q[2:0], accept};
            out_valid_q <= vld_q[3];
            out_data_q  <= vld_q[3] ? rs_data : '0;
            out_sat_q   <= vld_q[3] && rs_sat;
        end
    end

    // A write landing in the SWAP cycle updates shadow after active has copied the old contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            mode_q        <= MODE_SYM;
            commit_busy_q <= 1'b0;
            for (int k = 0; k < COEF_NUM; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
        end else begin
            if (coef_wr_en && 32'(coef_wr_addr) < COEF_NUM) shadow_q[coef_wr_addr] <= coef_wr_data;
            if (state_q == ST_RUN && coef_commit) begin
                state_q       <= ST_DRAIN;
                commit_busy_q <= 1'b1;
            end else if (state_q == ST_DRAIN && vld_q == '0 && !out_valid_q) begin
                state_q <= ST_SWAP;
            end else if (state_q == ST_SWAP) begin
                active_q      <= shadow_q;
                mode_q        <= sym_mode_e'(mode);
                state_q       <= ST_RUN;
                commit_busy_q <= 1'b0;
            end
        end
    end

`ifdef ADAPTIVE_FILTER_SAT_CNT_EN
    logic [15:0] sat_cnt_q;

    assign sat_cnt = sat_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sat_cnt_q <= '0;
        else if (state_q == ST_SWAP) sat_cnt_q <= '0;
        else if (out_valid_q && out_ready && out_sat_q && sat_cnt_q != 16'hFFFF) sat_cnt_q <= sat_cnt_q + 16'd1;
    end
`endif

endmodule

// File: doc/sym_fir_core.md
Name: sym_fir_core

Overview:
- Parametrised linear-phase FIR engine; the next generation of the fixed 10-tap differentiator/integrator filters in adaptive_filter.
- Supports even tap count via symmetric pre-add or antisymmetric pre-subtract, selectable at runtime.
- Coefficients are runtime-loadable through a shadow bank with atomic commit.
- Fully pipelined with valid/ready backpressure; output is rounded and saturated fixed-point.

Parameters:
- ORDER, 9, filter order; must be odd (tap count ORDER+1 even); elaboration assertion otherwise.
- DATA_WIDTH, 14, input word length.
- DATA_FL, 6, input fractional length.
- COEF_WIDTH, 9, coefficient word length (signed).
- COEF_FL, 7, coefficient fractional length.
- OUT_WIDTH, 20, output word length.
- OUT_FL, 12, output fractional length; must be ≤ DATA_FL+COEF_FL.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  core accepts sample.
- in_data  in  DATA_WIDTH  signed sample.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream accepts.
- out_data  out  OUT_WIDTH  signed filtered sample.
- out_sat  out  1  out_data was saturated.
- coef_wr_en  in  1  write shadow coefficient.
- coef_wr_addr  in  $clog2(COEF_NUM)  shadow index.
- coef_wr_data  in  COEF_WIDTH  coefficient value.
- coef_commit  in  1  request shadow→active copy.
- mode  in  1  0 = symmetric (pre-add), 1 = antisymmetric (pre-subtract); sampled on commit.
- commit_busy  out  1  commit pending.

Behaviour:
- COEF_NUM = (ORDER+1)/2.
- Reset: all outputs 0 except in_ready = 1. Delay line, both coefficient banks, active mode and pipeline valids cleared.
- Stall control: global stall when out_valid && !out_ready. in_ready = !stall && state==RUN.
- Delay line: ORDER+1 registers x[0..ORDER]. Shifts only on accept (in_valid && in_ready).
- Pipeline, advancing only when not stalled:
  - S1: pre-add p[k] = x[k] ± x[ORDER-k], width DATA_WIDTH+1.
  - S2: multiply m[k] = p[k]*c[k], width DATA_WIDTH+1+COEF_WIDTH, FL = DATA_FL+COEF_FL.
  - S3: adder-tree sum, width grows by $clog2(COEF_NUM).
  - S4: round half-up to OUT_FL, saturate to OUT_WIDTH; out_sat = 1 when clipped.
- Latency: out_valid rises 4 cycles after accept when unstalled. Throughput 1 sample/cycle.
- Output stability: while stalled, out_data, out_sat and out_valid hold.
- Shadow writes: take effect on the next edge. They never affect the active bank directly. The last write wins.
- FSM RUN / DRAIN / SWAP:
  - RUN: coef_commit → DRAIN.
  - DRAIN: in_ready = 0; when no stage valid (S1–S4 and out_valid all 0) → SWAP.
  - SWAP: active ← shadow, active mode ← mode input, commit_busy drops; → RUN next cycle.
  - commit_busy = 1 in DRAIN and SWAP. coef_commit is ignored outside RUN.
- Simultaneous events: coef_wr_en during DRAIN/SWAP is allowed. A write in the SWAP cycle lands in shadow only after the copy.
- Delay line is not flushed by commit; history persists across coefficient changes.
- Reset mid-operation: immediate clear; in-flight samples are lost.

Optional Feature:
- Macro: ADAPTIVE_FILTER_SAT_CNT_EN.
- Defined: adds output port sat_cnt (16 bits), incrementing on each out_valid&&out_ready with out_sat=1. It holds at 16'hFFFF, is cleared by reset and in SWAP, and adds 16 flops.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package sym_fir_pkg holds:
  - the mode enum (MODE_SYM, MODE_ASYM);
  - the FSM state typedef;
  - width-derivation functions (pre-add, product and accumulator widths);
  - the round/saturate function.
- One sub-module, sym_fir_round_sat: parametrised round-half-up plus saturation, combinational feeding the S4 register.

Test Plan:
- Symmetric impulse: load c0 = 9'h080, others 0; commit mode=0; feed 14'h0040 then zeros, out_ready=1. Expect out_data = 20'h01000 for accepted samples 0 and 9, 4 cycles after each; all other outputs 0.
- Antisymmetric impulse: same with mode=1. Expect 20'h01000 at sample 0 and 20'hFF000 (−1.0) at sample 9.
- Saturation: all coefs 9'h0FF, mode=0, constant input 14'h1FFF. Expect out_data = 20'h7FFFF with out_sat=1 once the line fills; with 14'h2000 input expect 20'h80000. With ADAPTIVE_FILTER_SAT_CNT_EN, sat_cnt increments per handshake.
- Backpressure: stream samples and hold out_ready=0 for 5 cycles. Expect in_ready=0 and out_data stable throughout; no sample lost or duplicated versus a golden model.
- Commit mid-stream: assert coef_commit with 3 samples in flight. Expect in_ready=0 until drained, commit_busy high for drain+1 cycles, new coefficients applied from the next accepted sample.
- Reset mid-stream: assert rst during streaming. Expect all outputs 0 and in_ready=1 immediately; the first post-reset output uses zeroed history and zero coefficients (out_data = 0).
